// File: rtl/load_store_controller.sv
// Execute-stage load/store sequencer: drives a valid/ready data-memory bus, stalls the
// pipeline until the access retires, and returns lane-extracted, extended load data.
module load_store_controller #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic            i_ex_load,
  input  logic            i_ex_store,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_addr,
  input  logic [XLEN-1:0] i_ex_wdata,
  output logic            o_ex_stall,
  output logic            o_ld_valid,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_addr_fault,
  output logic            o_bus_err,
  output logic            o_dm_avalid,
  input  logic            i_dm_aready,
  output logic [XLEN-1:0] o_dm_addr,
  output logic            o_dm_wen,
  output logic [3:0]      o_dm_wstrb,
  output logic [XLEN-1:0] o_dm_wdata,
  input  logic            i_dm_rvalid,
  input  logic [XLEN-1:0] i_dm_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RESP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;

  // Request decode on the raw execute-stage inputs.
  logic       mem_op;
  logic       legal_f3;
  logic       misaligned;
  logic       req_fault;
  logic [1:0] req_size;
  logic [1:0] req_off;

  always_comb begin
    req_size = i_ex_funct3[1:0];
    req_off  = i_ex_addr[1:0];
    mem_op   = i_ex_valid & (i_ex_load | i_ex_store);
    legal_f3 = 1'b0;
    if (i_ex_load) begin
      case (i_ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else begin
      case (i_ex_funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
    end
    misaligned = ((req_size == 2'b01) && req_off[0]) ||
                 ((req_size == 2'b10) && (req_off != 2'b00));
    req_fault  = ~legal_f3 | misaligned;
  end

  // Store lane placement: strobes follow the byte offset, data is replicated per lane.
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = i_ex_wdata;
    case (req_size)
      2'b00: begin
        st_wstrb = 4'b0001 << req_off;
        st_wdata = {4{i_ex_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << req_off;
        st_wdata = {2{i_ex_wdata[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = i_ex_wdata;
      end
    endcase
  end

  // Load lane extraction from the response word.
  logic [7:0]      rd_byte [4];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] ld_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = i_dm_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte = rd_byte[off_q];
    sel_half = off_q[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_ext = {24'd0, sel_byte};
      3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_ext = {16'd0, sel_half};
      default: ld_ext = i_dm_rdata;
    endcase
  end

  // A completing handshake in the last allowed cycle takes priority over the timeout.
  logic completes;
  logic timeout_hit;

  always_comb begin
    completes   = ((state_q == S_ADDR) && i_dm_aready && !is_load_q) ||
                  ((state_q == S_RESP) && i_dm_rvalid);
    timeout_hit = TIMEOUT_EN && ((state_q == S_ADDR) || (state_q == S_RESP)) &&
                  (cnt_q == CNT_LAST) && !completes;
  end

  logic stall_c;
  logic fault_c;
  logic bus_err_c;
  logic ld_valid_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_load_d  = is_load_q;
    funct3_d   = funct3_q;
    ld_data_d  = ld_data_q;
    stall_c    = 1'b0;
    fault_c    = 1'b0;
    bus_err_c  = 1'b0;
    ld_valid_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          if (req_fault) begin
            fault_c = 1'b1;
          end else begin
            stall_c   = 1'b1;
            addr_d    = {i_ex_addr[XLEN-1:2], 2'b00};
            off_d     = req_off;
            wdata_d   = st_wdata;
            wstrb_d   = st_wstrb;
            is_load_d = i_ex_load;
            funct3_d  = i_ex_funct3;
            cnt_d     = '0;
            state_d   = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (i_dm_aready) begin
          state_d = is_load_q ? S_RESP : S_DONE;
        end
      end
      S_RESP: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (i_dm_rvalid) begin
          ld_data_d = ld_ext;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        ld_valid_c = is_load_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      bus_err_c = 1'b1;
      state_d   = S_DONE;
      if (is_load_q) begin
        ld_data_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Input-driven outputs are forced low while reset is held so everything reads 0 at once.
  logic in_addr;
  assign in_addr = (state_q == S_ADDR);

  assign o_ex_stall   = stall_c & ~i_rst;
  assign o_addr_fault = fault_c & ~i_rst;
  assign o_bus_err    = bus_err_c & ~i_rst;
  assign o_ld_valid   = ld_valid_c;
  assign o_ld_data    = ld_data_q;
  assign o_dm_avalid  = in_addr;
  assign o_dm_addr    = in_addr ? addr_q : '0;
  assign o_dm_wen     = in_addr & ~is_load_q;
  assign o_dm_wstrb   = (in_addr && !is_load_q) ? wstrb_q : 4'b0000;
  assign o_dm_wdata   = (in_addr && !is_load_q) ? wdata_q : '0;

endmodule
